// File: rtl/redmule_pkg.sv
// Shared types and default sizes for the RedMulE TCDM arbiter.
package redmule_pkg;

    localparam int ARB_DW      = 288;
    localparam int ARB_AW      = 32;
    localparam int ARB_MAX_OUT = 4;

    // One channel's request fields at the default widths.
    typedef struct packed {
        logic [ARB_AW-1:0]   add;
        logic                wen;
        logic [ARB_DW-1:0]   data;
        logic [ARB_DW/8-1:0] be;
    } tcdm_arb_req_t;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// Outstanding-read ID FIFO: stores the channel ID of every granted read, in grant order.
// Push and pop may occur in the same cycle, including when full.
module redmule_arb_id_fifo #(
    parameter int IW    = 2,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [IW-1:0] data_i,
    input  logic          pop_i,
    output logic [IW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// N-channel round-robin TCDM arbiter with in-order read-response routing.
// Optional performance counters are built when REDMULE_TCDM_ARB_PERF_EN is defined.
module redmule_tcdm_arbiter
    import redmule_pkg::*;
#(
    parameter int NB_CH   = 4,
    parameter int DW      = ARB_DW,
    parameter int AW      = ARB_AW,
    parameter int MAX_OUT = ARB_MAX_OUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [NB_CH-1:0]      ch_en_i,
    input  logic [NB_CH-1:0]      ch_req_i,
    output logic [NB_CH-1:0]      ch_gnt_o,
    input  logic [NB_CH*AW-1:0]   ch_add_i,
    input  logic [NB_CH-1:0]      ch_wen_i,
    input  logic [NB_CH*DW-1:0]   ch_data_i,
    input  logic [NB_CH*DW/8-1:0] ch_be_i,
    output logic [NB_CH-1:0]      ch_rvalid_o,
    output logic [DW-1:0]         ch_rdata_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [AW-1:0]         tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [DW-1:0]         tcdm_data_o,
    output logic [DW/8-1:0]       tcdm_be_o,
    input  logic                  tcdm_rvalid_i,
    input  logic [DW-1:0]         tcdm_rdata_i,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [NB_CH*32-1:0]   perf_gnt_o,
    output logic [31:0]           perf_stall_o
);
    localparam int IW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic             flush;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    winner;
    logic [NB_CH-1:0] eligible;
    logic             gnt;
    logic             err_q;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IW-1:0]    fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             found;
    int               idx;

    assign flush = rst_i | clear_i;

    // A read may only win if its ID has somewhere to go this cycle.
    assign eligible = ch_req_i & ch_en_i & ~(ch_wen_i & {NB_CH{fifo_full & ~fifo_pop}});

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NB_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NB_CH) idx = idx - NB_CH;
            if (!found && eligible[idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    assign tcdm_req_o  = found & ~flush;
    assign gnt         = tcdm_req_o & tcdm_gnt_i;
    assign ch_gnt_o    = gnt ? (NB_CH'(1) << winner) : '0;
    assign tcdm_add_o  = tcdm_req_o ? ch_add_i[winner*AW +: AW] : '0;
    assign tcdm_wen_o  = tcdm_req_o & ch_wen_i[winner];
    assign tcdm_data_o = tcdm_req_o ? ch_data_i[winner*DW +: DW] : '0;
    assign tcdm_be_o   = tcdm_req_o ? ch_be_i[winner*(DW/8) +: DW/8] : '0;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            rr_ptr <= '0;
        end else if (gnt && NB_CH > 1) begin
            rr_ptr <= (winner == IW'(NB_CH - 1)) ? '0 : winner + 1'b1;
        end
    end

    assign fifo_push = gnt & ch_wen_i[winner];
    assign fifo_pop  = tcdm_rvalid_i & ~fifo_empty & ~flush;

    redmule_arb_id_fifo #(
        .IW    (IW),
        .DEPTH (MAX_OUT),
        .CW    (CW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (flush),
        .push_i  (fifo_push),
        .data_i  (winner),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign ch_rvalid_o = fifo_pop ? (NB_CH'(1) << fifo_head) : '0;
    assign ch_rdata_o  = tcdm_rdata_i;
    assign busy_o      = (fifo_count != '0);

    // A response with no matching outstanding read is a protocol error; it stays flagged.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            err_q <= 1'b0;
        end else if (tcdm_rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;

`ifdef REDMULE_TCDM_ARB_PERF_EN
    logic [31:0] perf_gnt_q [NB_CH];
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            for (int i = 0; i < NB_CH; i++) perf_gnt_q[i] <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < NB_CH; i++) begin
                if (ch_gnt_o[i] && perf_gnt_q[i] != '1) perf_gnt_q[i] <= perf_gnt_q[i] + 1'b1;
            end
            if (tcdm_req_o && !tcdm_gnt_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    for (genvar g = 0; g < NB_CH; g++) begin : g_perf
        assign perf_gnt_o[g*32 +: 32] = perf_gnt_q[g];
    end
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_gnt_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Directed self-checking bench for redmule_tcdm_arbiter (NB_CH=4, MAX_OUT=2).
module tb_redmule_tcdm_arbiter;
    localparam int NB_CH   = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int MAX_OUT = 2;
`ifdef REDMULE_TCDM_ARB_PERF_EN
    localparam int EXP_G1 = 10;
    localparam int EXP_ST = 3;
`else
    localparam int EXP_G1 = 0;
    localparam int EXP_ST = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clear = 1'b0;
    logic [NB_CH-1:0]      ch_en = '1;
    logic [NB_CH-1:0]      ch_req = '0;
    logic [NB_CH-1:0]      ch_gnt;
    logic [NB_CH*AW-1:0]   ch_add;
    logic [NB_CH-1:0]      ch_wen = '1;
    logic [NB_CH*DW-1:0]   ch_data;
    logic [NB_CH*DW/8-1:0] ch_be = '1;
    logic [NB_CH-1:0]      ch_rvalid;
    logic [DW-1:0]         ch_rdata;
    logic                  tcdm_req;
    logic                  tcdm_gnt = 1'b1;
    logic [AW-1:0]         tcdm_add;
    logic                  tcdm_wen;
    logic [DW-1:0]         tcdm_data;
    logic [DW/8-1:0]       tcdm_be;
    logic                  tcdm_rvalid = 1'b0;
    logic [DW-1:0]         tcdm_rdata = '0;
    logic                  busy;
    logic                  err;
    logic [NB_CH*32-1:0]   perf_gnt;
    logic [31:0]           perf_stall;

    int tests = 0;
    int fails = 0;
    int resp_q[$];
    int e;

    always #5 clk = ~clk;

    redmule_tcdm_arbiter #(
        .NB_CH(NB_CH), .DW(DW), .AW(AW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .ch_en_i(ch_en), .ch_req_i(ch_req), .ch_gnt_o(ch_gnt),
        .ch_add_i(ch_add), .ch_wen_i(ch_wen), .ch_data_i(ch_data), .ch_be_i(ch_be),
        .ch_rvalid_o(ch_rvalid), .ch_rdata_o(ch_rdata),
        .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
        .tcdm_wen_o(tcdm_wen), .tcdm_data_o(tcdm_data), .tcdm_be_o(tcdm_be),
        .tcdm_rvalid_i(tcdm_rvalid), .tcdm_rdata_i(tcdm_rdata),
        .busy_o(busy), .err_o(err),
        .perf_gnt_o(perf_gnt), .perf_stall_o(perf_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return every outstanding read, checking routing against the expected ID order.
    task automatic drain(input string tag);
        ch_req = '0;
        while (resp_q.size() > 0) begin
            tcdm_rvalid = 1'b1;
            #2;
            e = resp_q.pop_front();
            check(tag, ch_rvalid, 64'(1 << e));
            tick();
        end
        tcdm_rvalid = 1'b0;
        #2;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < NB_CH; i++) begin
            ch_add[i*AW +: AW]  = 32'h1000 + i;
            ch_data[i*DW +: DW] = 32'hD000 + i;
        end

        // Reset: outputs quiet even with requests present
        ch_req = '1;
        tick();
        #2;
        check("rst_req", tcdm_req, 0);
        check("rst_gnt", ch_gnt, 0);
        check("rst_add", tcdm_add, 0);
        tick();
        rst = 1'b0;
        ch_req = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_perf", perf_stall, 0);
        tick();

        // 1: all channels read, round-robin 0,1,2,3,..., responses follow one cycle later
        for (int k = 0; k < 8; k++) begin
            ch_req = '1;
            tcdm_rvalid = (k > 0);
            tcdm_rdata = 32'hA000 + k;
            #2;
            check("t1_gnt", ch_gnt, 64'(1 << (k % 4)));
            check("t1_add", tcdm_add, 32'h1000 + (k % 4));
            if (k > 0) begin
                e = resp_q.pop_front();
                check("t1_rvalid", ch_rvalid, 64'(1 << e));
                check("t1_rdata", ch_rdata, 32'hA000 + k);
            end
            resp_q.push_back(k % 4);
            tick();
        end
        drain("t1_drain");
        tick();

        // 2: only channels 1 and 3 enabled -> alternate
        ch_en = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            ch_req = '1;
            tcdm_rvalid = (k > 0);
            #2;
            check("t2_gnt", ch_gnt, (k % 2 == 0) ? 64'h2 : 64'h8);
            if (k > 0) begin
                e = resp_q.pop_front();
                check("t2_rvalid", ch_rvalid, 64'(1 << e));
            end
            resp_q.push_back((k % 2 == 0) ? 1 : 3);
            tick();
        end
        drain("t2_drain");
        ch_en = '1;
        tick();

        // 3: fill the two-entry ID FIFO from ch0, reads then block but a write still passes
        for (int k = 0; k < 2; k++) begin
            ch_req = 4'b0001;
            #2;
            check("t3_fill_gnt", ch_gnt, 64'h1);
            resp_q.push_back(0);
            tick();
        end
        #2;
        check("t3_full_gnt", ch_gnt, 0);
        check("t3_full_req", tcdm_req, 0);
        check("t3_busy", busy, 1);
        tick();
        ch_req = 4'b0101;
        ch_wen = 4'b1011;
        #2;
        check("t3_wr_gnt", ch_gnt, 64'h4);
        check("t3_wr_wen", tcdm_wen, 0);
        check("t3_wr_data", tcdm_data, 32'hD002);
        tick();
        ch_wen = '1;

        // 4: full FIFO, pop and push together; IDs still come back in order
        ch_req = 4'b0001;
        tcdm_rvalid = 1'b1;
        #2;
        e = resp_q.pop_front();
        check("t4_rvalid0", ch_rvalid, 64'(1 << e));
        check("t4_gnt0", ch_gnt, 64'h1);
        resp_q.push_back(0);
        tick();
        check("t4_busy", busy, 1);
        ch_req = 4'b0010;
        #2;
        e = resp_q.pop_front();
        check("t4_rvalid1", ch_rvalid, 64'(1 << e));
        check("t4_gnt1", ch_gnt, 64'h2);
        resp_q.push_back(1);
        tick();
        drain("t4_drain");
        tick();

        // 5: response with empty FIFO -> no routing, sticky error until clear
        tcdm_rvalid = 1'b1;
        #2;
        check("t5_rvalid", ch_rvalid, 0);
        tick();
        tcdm_rvalid = 1'b0;
        tick();
        check("t5_err", err, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #2;
        check("t5_err_clr", err, 0);
        // clear with a read outstanding: flushed, late response flags error
        ch_req = 4'b0001;
        #2;
        check("t5_gnt", ch_gnt, 64'h1);
        tick();
        clear = 1'b1;
        #2;
        check("t5_clr_gnt", ch_gnt, 0);
        check("t5_clr_req", tcdm_req, 0);
        tick();
        clear = 1'b0;
        ch_req = '0;
        tcdm_rvalid = 1'b1;
        #2;
        check("t5_late_rvalid", ch_rvalid, 0);
        check("t5_flushed", busy, 0);
        tick();
        tcdm_rvalid = 1'b0;
        check("t5_late_err", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_err", err, 0);

        // 6: performance counters, 10 write grants to ch1 then 3 stalled cycles
        ch_req = 4'b0010;
        ch_wen = 4'b0000;
        for (int k = 0; k < 10; k++) tick();
        tcdm_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("t6_stall_gnt", ch_gnt, 0);
            tick();
        end
        ch_req = '0;
        tcdm_gnt = 1'b1;
        tick();
        check("t6_perf_gnt1", perf_gnt[32 +: 32], EXP_G1);
        check("t6_perf_gnt0", perf_gnt[0 +: 32], 0);
        check("t6_perf_stall", perf_stall, EXP_ST);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
